// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES equal segments,
// one segment per pipeline stage, with a global valid/ready stall.
module pipelined_addsub #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow
);

  localparam int SEG = WIDTH / STAGES;

  // Handshake: a transfer happens on a side when its valid && ready are both high
  // at a rising edge; ready never depends on the same side's valid.
  logic advance;

  // Stage registers: operands (b already inverted for subtract), partial result, segment carry.
  logic             v_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] r_q [STAGES];
  logic             c_q [STAGES];

  // Inputs seen by each stage: stage 0 takes the ports, later stages the previous register.
  logic             src_v [STAGES];
  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_r [STAGES];
  logic             src_c [STAGES];
  logic [WIDTH-1:0] nr    [STAGES];
  logic             nc    [STAGES];
  logic [SEG:0]     seg_sum;

  always_comb begin
    src_v[0] = in_valid;
    src_a[0] = ain;
    src_b[0] = sub ? ~bin : bin;
    src_r[0] = '0;
    src_c[0] = sub ? ~cin : cin;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = v_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_r[k] = r_q[k-1];
      src_c[k] = c_q[k-1];
    end
  end

  always_comb begin
    seg_sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      nr[k] = src_r[k];
      nc[k] = 1'b0;
      seg_sum = {1'b0, src_a[k][k*SEG +: SEG]} + {1'b0, src_b[k][k*SEG +: SEG]}
              + {{SEG{1'b0}}, src_c[k]};
      nr[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
      nc[k] = seg_sum[SEG];
    end
  end

  // Stage data only loads with a valid op so out and flags hold across bubbles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= src_v[k];
        if (src_v[k]) begin
          a_q[k] <= src_a[k];
          b_q[k] <= src_b[k];
          r_q[k] <= nr[k];
          c_q[k] <= nc[k];
        end
      end
    end
  end

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = v_q[STAGES-1];
  assign out       = r_q[STAGES-1];
  assign carry_out = c_q[STAGES-1];
  // Derived purely from last-stage registers, so it changes only together with out.
  assign overflow  = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                     (r_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: three instances (8/2, 8/1, 16/4) share
// stimulus; sel picks which one is driven and observed.
module tb_pipelined_addsub;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic [1:0]  sel;
  logic        in_valid, sub, cin, out_ready;
  logic [15:0] ain, bin;

  logic       m_in_ready, m_out_valid, m_co, m_ov;
  logic [7:0] m_out;
  logic       s1_in_ready, s1_out_valid, s1_co, s1_ov;
  logic [7:0] s1_out;
  logic        w_in_ready, w_out_valid, w_co, w_ov;
  logic [15:0] w_out;

  logic        in_ready, out_valid, co, ov;
  logic [15:0] out;

  int passed = 0;
  int total  = 0;

  pipelined_addsub #(.WIDTH(8), .STAGES(2)) u_main (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid && sel == 2'd0), .in_ready(m_in_ready),
    .ain(ain[7:0]), .bin(bin[7:0]), .sub(sub), .cin(cin),
    .out_valid(m_out_valid), .out_ready(out_ready || sel != 2'd0),
    .out(m_out), .carry_out(m_co), .overflow(m_ov)
  );

  pipelined_addsub #(.WIDTH(8), .STAGES(1)) u_s1 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid && sel == 2'd1), .in_ready(s1_in_ready),
    .ain(ain[7:0]), .bin(bin[7:0]), .sub(sub), .cin(cin),
    .out_valid(s1_out_valid), .out_ready(out_ready || sel != 2'd1),
    .out(s1_out), .carry_out(s1_co), .overflow(s1_ov)
  );

  pipelined_addsub #(.WIDTH(16), .STAGES(4)) u_wide (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid && sel == 2'd2), .in_ready(w_in_ready),
    .ain(ain), .bin(bin), .sub(sub), .cin(cin),
    .out_valid(w_out_valid), .out_ready(out_ready || sel != 2'd2),
    .out(w_out), .carry_out(w_co), .overflow(w_ov)
  );

  assign in_ready  = (sel == 2'd0) ? m_in_ready  : (sel == 2'd1) ? s1_in_ready  : w_in_ready;
  assign out_valid = (sel == 2'd0) ? m_out_valid : (sel == 2'd1) ? s1_out_valid : w_out_valid;
  assign out       = (sel == 2'd0) ? {8'h00, m_out} : (sel == 2'd1) ? {8'h00, s1_out} : w_out;
  assign co        = (sel == 2'd0) ? m_co : (sel == 2'd1) ? s1_co : w_co;
  assign ov        = (sel == 2'd0) ? m_ov : (sel == 2'd1) ? s1_ov : w_ov;

  // Driver: one operand transfer, then wait (bounded) for out_valid; lat counts edges.
  task automatic drive_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic c, output int lat);
    @(posedge clock); #1;
    in_valid = 1'b1; ain = a; bin = b; sub = s; cin = c; out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; ain = 16'($urandom); bin = 16'($urandom);
    sub = 1'($urandom); cin = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if ({m_out_valid, m_out, m_co, m_ov} !== 11'h000)
      $display("FAIL reset_main got v=%b out=%h co=%b ov=%b want all zero",
               m_out_valid, m_out, m_co, m_ov);
    else passed++;
    total++;
    if ({s1_out_valid, w_out_valid, w_out} !== 18'h0)
      $display("FAIL reset_others got s1_v=%b w_v=%b w_out=%h want all zero",
               s1_out_valid, w_out_valid, w_out);
    else passed++;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
    else passed++;
  endtask

  task automatic test_basic_add(input int exp_lat);
    int lat;
    drive_op(16'h000F, 16'h0001, 1'b0, 1'b0, lat);
    total++;
    if (lat !== exp_lat) $display("FAIL add_0f_01_latency sel=%0d got %0d want %0d", sel, lat, exp_lat);
    else passed++;
    total++;
    if ({out, co, ov} !== {16'h0010, 1'b0, 1'b0})
      $display("FAIL add_0f_01 sel=%0d got out=%h co=%b ov=%b want 0010/0/0", sel, out, co, ov);
    else passed++;
  endtask

  task automatic test_add_flags();
    int lat;
    drive_op(16'h007F, 16'h0001, 1'b0, 1'b0, lat);
    total++;
    if ({out, co, ov} !== {16'h0080, 1'b0, 1'b1})
      $display("FAIL add_7f_01 got out=%h co=%b ov=%b want 0080/0/1", out, co, ov);
    else passed++;
    drive_op(16'h00FF, 16'h0001, 1'b0, 1'b1, lat);
    total++;
    if ({out, co, ov} !== {16'h0001, 1'b1, 1'b0})
      $display("FAIL add_ff_01_c1 got out=%h co=%b ov=%b want 0001/1/0", out, co, ov);
    else passed++;
  endtask

  task automatic test_sub(input int exp_lat);
    int lat;
    drive_op(16'h0005, 16'h0007, 1'b1, 1'b0, lat);
    total++;
    if (lat !== exp_lat) $display("FAIL sub_latency sel=%0d got %0d want %0d", sel, lat, exp_lat);
    else passed++;
    total++;
    if ({out, co, ov} !== {16'h00FE, 1'b0, 1'b0})
      $display("FAIL sub_05_07 sel=%0d got out=%h co=%b ov=%b want 00fe/0/0", sel, out, co, ov);
    else passed++;
    drive_op(16'h0080, 16'h0001, 1'b1, 1'b0, lat);
    total++;
    if ({out, co, ov} !== {16'h007F, 1'b1, 1'b1})
      $display("FAIL sub_80_01 sel=%0d got out=%h co=%b ov=%b want 007f/1/1", sel, out, co, ov);
    else passed++;
    drive_op(16'h0010, 16'h0000, 1'b1, 1'b1, lat);
    total++;
    if ({out, co, ov} !== {16'h000F, 1'b1, 1'b0})
      $display("FAIL sub_10_00_b1 sel=%0d got out=%h co=%b ov=%b want 000f/1/0", sel, out, co, ov);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int idx = 0, stall_left = 0, nxfer = 0, last_cyc = -1, gaps = 0;
    bit seen = 1'b0;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] got;
    exp_q = '{16'h0002, 16'h0004, 16'h0006, 16'h0008};
    for (int cyc = 0; cyc < 40 && nxfer < 4; cyc++) begin
      @(posedge clock); #1;
      if (out_valid && !seen) begin
        seen = 1'b1;
        stall_left = 3;
      end
      out_ready = (stall_left == 0);
      in_valid  = (idx < 4);
      ain = 16'(idx + 1); bin = 16'(idx + 1); sub = 1'b0; cin = 1'b0;
      @(negedge clock);
      if (stall_left > 0) begin
        total++;
        if ({out_valid, out, in_ready} !== {1'b1, 16'h0002, 1'b0})
          $display("FAIL b2b_stall sel=%0d got v=%b out=%h in_ready=%b want 1/0002/0",
                   sel, out_valid, out, in_ready);
        else passed++;
        stall_left--;
      end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        got_q.push_back(out);
        if (last_cyc >= 0 && cyc != last_cyc + 1) gaps++;
        last_cyc = cyc;
        nxfer++;
      end
    end
    @(posedge clock); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    total++;
    if (got_q.size() != 4) $display("FAIL b2b_count sel=%0d got %0d want 4", sel, got_q.size());
    else passed++;
    while (exp_q.size() > 0) begin
      got = (got_q.size() > 0) ? got_q.pop_front() : 16'hxxxx;
      total++;
      if (got !== exp_q[0]) $display("FAIL b2b_order sel=%0d got %h want %h", sel, got, exp_q[0]);
      else passed++;
      void'(exp_q.pop_front());
    end
    total++;
    if (gaps !== 0) $display("FAIL b2b_gaps sel=%0d got %0d want 0", sel, gaps);
    else passed++;
  endtask

  task automatic test_reset_midstream();
    int lat, stale = 0;
    @(posedge clock); #1;
    in_valid = 1'b1; ain = 16'h0011; bin = 16'h0022; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    ain = 16'h0033; bin = 16'h0044;
    @(posedge clock); #1;
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out, co, ov} !== {1'b0, 16'h0000, 1'b0, 1'b0})
      $display("FAIL midreset_flush got v=%b out=%h co=%b ov=%b want 0/0000/0/0",
               out_valid, out, co, ov);
    else passed++;
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (out_valid) stale++;
    end
    total++;
    if (stale !== 0) $display("FAIL midreset_stale got %0d stale cycles want 0", stale);
    else passed++;
    total++;
    if (in_ready !== 1'b1) $display("FAIL midreset_in_ready got %b want 1", in_ready);
    else passed++;
    drive_op(16'h0001, 16'h0001, 1'b0, 1'b0, lat);
    total++;
    if ({lat, out} !== {32'd2, 16'h0002})
      $display("FAIL midreset_next got lat=%0d out=%h want 2/0002", lat, out);
    else passed++;
  endtask

  task automatic test_wide();
    int lat;
    drive_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    total++;
    if (lat !== 4) $display("FAIL wide_latency got %0d want 4", lat);
    else passed++;
    total++;
    if ({out, co, ov} !== {16'h0000, 1'b1, 1'b0})
      $display("FAIL wide_ffff_0001 got out=%h co=%b ov=%b want 0000/1/0", out, co, ov);
    else passed++;
    drive_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    total++;
    if ({out, co, ov} !== {16'h8000, 1'b0, 1'b1})
      $display("FAIL wide_7fff_0001 got out=%h co=%b ov=%b want 8000/0/1", out, co, ov);
    else passed++;
    drive_op(16'h0000, 16'h0001, 1'b1, 1'b0, lat);
    total++;
    if ({out, co, ov} !== {16'hFFFF, 1'b0, 1'b0})
      $display("FAIL wide_0000_sub_0001 got out=%h co=%b ov=%b want ffff/0/0", out, co, ov);
    else passed++;
  endtask

  initial begin
    sel = 2'd0; in_valid = 1'b0; ain = '0; bin = '0; sub = 1'b0; cin = 1'b0;
    out_ready = 1'b1; reset_n = 1'b0;
    test_reset();
    test_basic_add(2);
    test_add_flags();
    test_sub(2);
    test_back_to_back();
    test_reset_midstream();
    sel = 2'd1;
    test_basic_add(1);
    test_sub(1);
    test_back_to_back();
    sel = 2'd2;
    test_basic_add(4);
    test_wide();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined adder/subtractor; next generation of the team's clocked 4-bit adder.
- Adds configurable width, a carry chain split across pipeline stages, subtract mode and carry/borrow-in.
- Adds carry-out and signed-overflow flags, and valid/ready handshakes on both sides.
- Sits between operand sources (register file / decode) and result consumers in the datapath.

Parameters:
WIDTH, 8, operand and result width in bits; must be an integer multiple of STAGES.
STAGES, 2, pipeline depth and number of carry-chain segments; range 1..WIDTH; each segment is WIDTH/STAGES bits.

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  operands presented
in_ready  output  1  block accepts operands this cycle
ain  input  WIDTH  operand A
bin  input  WIDTH  operand B
sub  input  1  0 = add, 1 = subtract
cin  input  1  carry-in (add) / borrow-in (subtract)
out_valid  output  1  result presented
out_ready  input  1  consumer accepts result this cycle
out  output  WIDTH  result
carry_out  output  1  add: carry; subtract: 1 = no borrow
overflow  output  1  signed two's-complement overflow

Behaviour:
- Reset (reset_n low, asynchronous):
  - All stage valid bits clear; out_valid = 0.
  - out = 0, carry_out = 0, overflow = 0.
  - All in-flight operations are discarded.
  - in_ready = 1 from the first edge after reset_n deasserts.
- Arithmetic:
  - Add: out = ain + bin + cin.
  - Subtract: out = ain + ~bin + ~cin (i.e. ain - bin - cin).
  - carry_out is the carry out of the MSB, WIDTH+1-bit view.
  - overflow = (a_msb == b_eff_msb) && (out_msb != a_msb), where b_eff = sub ? ~bin : bin.
- Pipeline:
  - Stage k (0-based) computes bits [(k+1)*W/S-1 : k*W/S] using the carry registered from stage k-1.
  - Stage 0's carry-in is sub ? ~cin : cin.
  - Unprocessed operand slices, completed result slices, the MSB-derived operand bits and sub are carried forward in stage registers.
  - Output registers are the last stage; flags are registered with out.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance (combinational, no dependence on in_valid).
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - When advance = 1, every stage shifts one position. Stage 0 loads the operand (valid = in_valid).
  - When advance = 0, every stage, including out / out_valid / flags, holds.
  - Global stall: bubbles are not collapsed.
- Latency: exactly STAGES cycles from input transfer to out_valid with no stall. Throughput: 1 op/cycle while out_ready = 1.
- Ordering: results emerge strictly in acceptance order; no drop, no duplication.
- Output stability: while out_valid && !out_ready, out, carry_out and overflow are stable.
- When out_valid = 0, out and flags hold their last value (0 after reset) and are don't-care for checking.
- STAGES = 1: single registered full-width add, latency 1.
- STAGES = WIDTH: 1-bit segments, ripple fully pipelined.
- Simultaneous output and input transfer in the same cycle is legal and sustains full rate.
- Operand inputs are sampled only on an input transfer; changes on other cycles have no effect.
- Reset asserted mid-stream: everything is flushed immediately. No result from before reset appears after it.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1: add 8'h0F + 8'h01, cin=0 accepted at cycle t -> out_valid at t+2, out=8'h10, carry_out=0, overflow=0.
- Add 8'h7F + 8'h01 -> out=8'h80, carry_out=0, overflow=1. Add 8'hFF + 8'h01, cin=1 -> out=8'h01, carry_out=1, overflow=0 (exercises cross-segment carry).
- Subtract 8'h05 - 8'h07, cin=0 -> out=8'hFE, carry_out=0, overflow=0. Subtract 8'h80 - 8'h01 -> out=8'h7F, carry_out=1, overflow=1. Subtract 8'h10 - 8'h00, cin=1 -> out=8'h0F, carry_out=1.
- Back-to-back stream of 4 adds (1+1, 2+2, 3+3, 4+4), with out_ready held low for 3 cycles after the first result:
  - out stays 8'h02 and in_ready = 0 during the stall.
  - Afterwards results 02, 04, 06, 08 appear in order, with no gaps once out_ready = 1.
- Assert reset_n low for 1 cycle while 2 ops are in flight -> out_valid drops immediately and out = 0. No stale result afterwards. The next op (8'h01 + 8'h01) yields 8'h02 after 2 cycles.
- Repeat the first, third and fourth scenarios with STAGES=1 (latency 1) and with WIDTH=16, STAGES=4: 16'hFFFF + 16'h0001 -> out=16'h0000, carry_out=1, latency 4.
